// File: rtl/wb_io_arbiter.sv
// wb_io_arbiter: two-master Wishbone arbiter onto one shared io slave port, round-robin on ties.
// Define WB_IO_ARBITER_TIMEOUT_EN to add the slave-response timeout counter and ABORT state.
module wb_io_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rstn_i,
   input  logic [31:0] wbm0_adr_i,
   input  logic [31:0] wbm0_dat_i,
   input  logic [3:0]  wbm0_sel_i,
   input  logic        wbm0_we_i,
   input  logic        wbm0_cyc_i,
   input  logic        wbm0_stb_i,
   input  logic [2:0]  wbm0_cti_i,
   input  logic [1:0]  wbm0_bte_i,
   output logic [31:0] wbm0_dat_o,
   output logic        wbm0_ack_o,
   output logic        wbm0_err_o,
   output logic        wbm0_rty_o,
   input  logic [31:0] wbm1_adr_i,
   input  logic [31:0] wbm1_dat_i,
   input  logic [3:0]  wbm1_sel_i,
   input  logic        wbm1_we_i,
   input  logic        wbm1_cyc_i,
   input  logic        wbm1_stb_i,
   input  logic [2:0]  wbm1_cti_i,
   input  logic [1:0]  wbm1_bte_i,
   output logic [31:0] wbm1_dat_o,
   output logic        wbm1_ack_o,
   output logic        wbm1_err_o,
   output logic        wbm1_rty_o,
   output logic [31:0] wbs_adr_o,
   output logic [31:0] wbs_dat_o,
   output logic [3:0]  wbs_sel_o,
   output logic        wbs_we_o,
   output logic        wbs_cyc_o,
   output logic        wbs_stb_o,
   output logic [2:0]  wbs_cti_o,
   output logic [1:0]  wbs_bte_o,
   input  logic [31:0] wbs_dat_i,
   input  logic        wbs_ack_i,
   input  logic        wbs_err_i,
   input  logic        wbs_rty_i,
   output logic [1:0]  grant_o
);

   typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;

   state_e state_q, state_d;
   logic   owner_q, owner_d;
   logic   last_owner_q, last_owner_d;
   logic   own_cyc, own_stb, resp, busy, abort, timeout_hit;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_io_arbiter: TIMEOUT_CYCLES must be within 2..65535");
   end

   assign own_cyc = owner_q ? wbm1_cyc_i : wbm0_cyc_i;
   assign own_stb = owner_q ? wbm1_stb_i : wbm0_stb_i;
   assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
   assign busy    = state_q == BUSY;
   assign abort   = state_q == ABORT;

`ifdef WB_IO_ARBITER_TIMEOUT_EN
   localparam logic [15:0] THRESH = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] cnt_q, cnt_d;

   // A response in the threshold cycle wins over the abort.
   assign timeout_hit = busy && own_stb && !resp && cnt_q == THRESH;

   always_comb begin
      cnt_d = (!busy || resp) ? 16'd0 : own_stb ? cnt_q + 16'd1 : cnt_q;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      unique case (state_q)
         IDLE: begin
            if (wbm0_cyc_i || wbm1_cyc_i) begin
               state_d = BUSY;
               owner_d = (wbm0_cyc_i && wbm1_cyc_i) ? ~last_owner_q : wbm1_cyc_i;
            end
         end
         BUSY: begin
            if (!own_cyc) begin
               state_d      = IDLE;
               last_owner_d = owner_q;
            end else if (timeout_hit) begin
               state_d = ABORT;
            end
         end
         ABORT: begin
            state_d      = own_cyc ? BUSY : IDLE;
            last_owner_d = own_cyc ? last_owner_q : owner_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
      end
   end

   assign wbs_adr_o = owner_q ? wbm1_adr_i : wbm0_adr_i;
   assign wbs_dat_o = owner_q ? wbm1_dat_i : wbm0_dat_i;
   assign wbs_sel_o = owner_q ? wbm1_sel_i : wbm0_sel_i;
   assign wbs_we_o  = owner_q ? wbm1_we_i  : wbm0_we_i;
   assign wbs_cti_o = owner_q ? wbm1_cti_i : wbm0_cti_i;
   assign wbs_bte_o = owner_q ? wbm1_bte_i : wbm0_bte_i;
   assign wbs_cyc_o = busy & own_cyc;
   assign wbs_stb_o = busy & own_stb;

   assign wbm0_dat_o = wbs_dat_i;
   assign wbm1_dat_o = wbs_dat_i;
   assign wbm0_ack_o = busy & ~owner_q & wbs_ack_i;
   assign wbm1_ack_o = busy &  owner_q & wbs_ack_i;
   assign wbm0_err_o = ~owner_q & ((busy & wbs_err_i) | abort);
   assign wbm1_err_o =  owner_q & ((busy & wbs_err_i) | abort);
   assign wbm0_rty_o = busy & ~owner_q & wbs_rty_i;
   assign wbm1_rty_o = busy &  owner_q & wbs_rty_i;

   assign grant_o = (busy | abort) ? {owner_q, ~owner_q} : 2'b00;

endmodule

// File: doc/wb_io_arbiter.md
WB_IO_ARBITER -- requirements
Module: wb_io_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning slave-response cycles before an abort; legal range 2..65535.
REQ-002 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports wbm{0,1}_adr_i/dat_i, input, 32/32 bits: master address and write data.
REQ-005 SHALL have ports wbm{0,1}_sel_i/we_i/cyc_i/stb_i/cti_i/bte_i, input, 4/1/1/1/3/2 bits: master controls.
REQ-006 SHALL have ports wbm{0,1}_dat_o/ack_o/err_o/rty_o, output, 32/1/1/1 bits: master responses.
REQ-007 SHALL have ports wbs_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o, output, 32/32/4/1/1/1/3/2 bits: shared slave port toward the io interconnect.
REQ-008 SHALL have ports wbs_dat_i/ack_i/err_i/rty_i, input, 32/1/1/1 bits: slave responses.
REQ-009 SHALL have port grant_o, output, 2 bits: one-hot current owner; 00 when idle.

Function
REQ-010 SHALL implement states IDLE, BUSY, ABORT plus a 1-bit owner register and a 1-bit last_owner register.
REQ-011 In IDLE, if exactly one wbm*_cyc_i is high, that master SHALL become owner and the state SHALL go to BUSY on the next edge.
REQ-012 In IDLE with both cyc high, the master not equal to last_owner SHALL be granted (round-robin).
REQ-013 Grant latency SHALL be exactly one cycle: slave cyc/stb are visible the cycle after the request is first seen in IDLE.
REQ-014 In BUSY, all wbs_* outputs except dat_i-derived SHALL combinationally mirror the owner's inputs.
REQ-015 In IDLE and ABORT, wbs_cyc_o and wbs_stb_o SHALL be 0.
REQ-016 wbs_dat_i SHALL be broadcast to both wbm*_dat_o.
REQ-017 ack/err/rty SHALL be routed only to the owner; the non-owner's ack_o/err_o/rty_o SHALL be 0 at all times.
REQ-018 In BUSY, when the owner's cyc_i drops, last_owner SHALL take the owner value, the state SHALL go to IDLE, and grant_o SHALL become 00.
REQ-019 The return to IDLE SHALL force a one-cycle bus gap before any re-grant.
REQ-020 A request from the non-owner during BUSY SHALL be held off and SHALL NOT disturb the owner's burst, including when cti_i indicates a burst.
REQ-021 A 16-bit timeout counter SHALL clear on entry to BUSY and on any slave ack/err/rty.
REQ-022 The timeout counter SHALL increment each BUSY cycle with owner stb high and no response.
REQ-023 When the counter equals TIMEOUT_CYCLES-1 and no response arrives, the state SHALL go to ABORT.
REQ-024 ABORT SHALL last one cycle, drive err_o=1 to the owner, and clear the counter.
REQ-025 After ABORT, the state SHALL go to BUSY if the owner cyc is still high, else to IDLE.
REQ-026 A slave response in the same cycle as the counter threshold SHALL win; no abort SHALL occur.

Reset
REQ-027 While wb_rstn_i=0: state=IDLE, owner=0, last_owner=1 (master 0 wins the first tie), counter=0, grant_o=00, wbs_cyc_o=wbs_stb_o=0, all wbm*_ack_o/err_o/rty_o=0.
REQ-028 Reset asserted mid-transfer SHALL drop wbs_cyc_o asynchronously; no response SHALL be forwarded to a master.

Configuration
REQ-029 Macro WB_IO_ARBITER_TIMEOUT_EN SHALL compile the timeout counter and ABORT state in.
REQ-030 Without WB_IO_ARBITER_TIMEOUT_EN, ABORT SHALL be unreachable and the counter absent; the owner SHALL wait indefinitely and TIMEOUT_CYCLES SHALL be ignored.

Verification
REQ-031 Only m0 reads 0x00001000 and slave acks after 2 cycles -> grant_o=01 one cycle after cyc, m0 ack_o one pulse, m1 ack_o stays 0.
REQ-032 m0 and m1 raise cyc in the same cycle after reset -> m0 granted first; after m0 drops cyc, one idle cycle, then grant_o=10.
REQ-033 Back-to-back simultaneous requests for 4 transactions -> grants alternate m0,m1,m0,m1.
REQ-034 With macro defined and TIMEOUT_CYCLES=8, the slave never responds -> m0 err_o pulses once exactly 8 stb cycles after grant and wbs_stb_o=0 in that cycle; without the macro, no err_o ever.
REQ-035 wb_rstn_i pulsed low during an m1 4-beat burst (cti=010) -> wbs_cyc_o=0 immediately; after release, a simultaneous request grants m0.
REQ-036 Slave ack coincides with the timeout threshold cycle -> owner sees ack_o=1, err_o=0.
